cpu_mem_arbiter: RTL and testbench

Shares a single backing-memory port between the pipeline's instruction-fetch (IMEM) and data (DMEM) request interfaces. It captures one-cycle request pulses from each requester and picks a winner with data-priority plus an anti-starvation counter. It issues the winner on the memory port and routes the response back to the owner. It sits between the pipeline top level and the unified memory/cache model.

---
 rtl/cpu_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// Shares one backing-memory port between the IMEM fetch and DMEM data requesters.
// DMEM has priority; a starvation counter forces an IMEM grant after STARVE_LIMIT DMEM wins.
module cpu_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic {OWN_IMEM, OWN_DMEM} owner_e;

  state_e      r_state, w_state_nx;
  owner_e      r_owner, w_owner_nx;
  logic [3:0]  r_starve, w_starve_nx;

  logic        r_i_pend, r_d_pend;
  logic [31:0] r_i_addr, r_d_addr, r_d_wdata;
  logic [3:0]  r_i_rmask, r_d_rmask, r_d_wmask;

  logic        w_resp, w_i_done, w_d_done, w_i_req, w_d_req, w_i_take, w_d_take;
  logic        w_i_pend_nx, w_d_pend_nx, w_grant, w_pick_d;
  logic [31:0] w_i_addr_nx, w_d_addr_nx, w_d_wdata_nx;
  logic [3:0]  w_i_rmask_nx, w_d_rmask_nx, w_d_wmask_nx;

  // Arbitration sees the post-edge pending view so a request captured at this
  // edge (including one arriving with its owner's resp) can be granted at once.
  always_comb begin
    w_resp       = (r_state == S_WAIT) && mem_resp;
    w_i_done     = w_resp && (r_owner == OWN_IMEM);
    w_d_done     = w_resp && (r_owner == OWN_DMEM);
    w_i_req      = |imem_rmask;
    w_d_req      = (|dmem_rmask) || (|dmem_wmask);
    w_i_take     = w_i_req && (!r_i_pend || w_i_done);
    w_d_take     = w_d_req && (!r_d_pend || w_d_done);
    w_i_pend_nx  = w_i_take || (r_i_pend && !w_i_done);
    w_d_pend_nx  = w_d_take || (r_d_pend && !w_d_done);
    w_i_addr_nx  = w_i_take ? imem_addr  : r_i_addr;
    w_i_rmask_nx = w_i_take ? imem_rmask : r_i_rmask;
    w_d_addr_nx  = w_d_take ? dmem_addr  : r_d_addr;
    w_d_rmask_nx = w_d_take ? dmem_rmask : r_d_rmask;
    w_d_wmask_nx = w_d_take ? dmem_wmask : r_d_wmask;
    w_d_wdata_nx = w_d_take ? dmem_wdata : r_d_wdata;

    w_grant  = ((r_state == S_IDLE) || w_resp) && (w_i_pend_nx || w_d_pend_nx);
    w_pick_d = w_d_pend_nx && (!w_i_pend_nx || (r_starve != LIMIT));

    w_state_nx  = r_state;
    w_owner_nx  = r_owner;
    w_starve_nx = r_starve;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nx = S_ISSUE;
      S_ISSUE: w_state_nx = S_WAIT;
      S_WAIT:  if (w_resp) w_state_nx = w_grant ? S_ISSUE : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (w_grant) begin
      w_owner_nx = w_pick_d ? OWN_DMEM : OWN_IMEM;
      if (w_pick_d && w_i_pend_nx)
        w_starve_nx = (r_starve == LIMIT) ? r_starve : r_starve + 4'd1;
      else
        w_starve_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_IMEM;
      r_starve  <= '0;
      r_i_pend  <= 1'b0;
      r_d_pend  <= 1'b0;
      r_i_addr  <= '0;
      r_i_rmask <= '0;
      r_d_addr  <= '0;
      r_d_rmask <= '0;
      r_d_wmask <= '0;
      r_d_wdata <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_owner   <= w_owner_nx;
      r_starve  <= w_starve_nx;
      r_i_pend  <= w_i_pend_nx;
      r_d_pend  <= w_d_pend_nx;
      r_i_addr  <= w_i_addr_nx;
      r_i_rmask <= w_i_rmask_nx;
      r_d_addr  <= w_d_addr_nx;
      r_d_rmask <= w_d_rmask_nx;
      r_d_wmask <= w_d_wmask_nx;
      r_d_wdata <= w_d_wdata_nx;
    end
  end

  // Memory port registers: masks live for the single ISSUE cycle, addr/wdata hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_rmask <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else if (w_grant) begin
      if (w_pick_d) begin
        mem_addr  <= w_d_addr_nx;
        mem_wmask <= w_d_wmask_nx;
        mem_rmask <= (|w_d_wmask_nx) ? '0 : w_d_rmask_nx;
        mem_wdata <= w_d_wdata_nx;
      end else begin
        mem_addr  <= w_i_addr_nx;
        mem_wmask <= '0;
        mem_rmask <= w_i_rmask_nx;
        mem_wdata <= '0;
      end
    end else if (r_state == S_ISSUE) begin
      mem_rmask <= '0;
      mem_wmask <= '0;
    end
  end

  assign imem_resp  = w_i_done;
  assign dmem_resp  = w_d_done;
  assign imem_rdata = w_i_done ? mem_rdata : '0;
  assign dmem_rdata = w_d_done ? mem_rdata : '0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Randomized scoreboard bench for cpu_mem_arbiter: a transaction-level model predicts
// each memory issue and requester response; a monitor compares what the DUT presents.
module tb_cpu_mem_arbiter;

  localparam int LIMIT = 4;
  localparam int N_CYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  cpu_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] addr; logic [3:0] rm; logic [3:0] wm; logic [31:0] wd; } iss_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_t;

  iss_t iss_q[$];
  rsp_t iq[$];
  rsp_t dq[$];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents in each cycle against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        chk("reset_mem_addr",  mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_mem_masks", {mem_rmask, mem_wmask}, 0);
      end
      if (mem_rmask !== 4'h0 || mem_wmask !== 4'h0) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue got addr %h rm %h wm %h expected none (cycle %0d)",
                   mem_addr, mem_rmask, mem_wmask, cyc);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("issue_addr", mem_addr, e.addr);
          chk("issue_rmask", mem_rmask, e.rm);
          chk("issue_wmask", mem_wmask, e.wm);
          if (e.wm != 4'h0) chk("issue_wdata", mem_wdata, e.wd);
        end
      end
      if (imem_resp === 1'b1) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_imem_resp got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          rsp_t r;
          r = iq.pop_front();
          chk("imem_resp_cycle", 64'(cyc), 64'(r.cyc));
          chk("imem_rdata", imem_rdata, r.data);
        end
      end else begin
        chk("imem_resp_known", {63'b0, imem_resp}, 0);
        chk("imem_rdata_idle", imem_rdata, 0);
      end
      if (dmem_resp === 1'b1) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dmem_resp got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          rsp_t r;
          r = dq.pop_front();
          chk("dmem_resp_cycle", 64'(cyc), 64'(r.cyc));
          chk("dmem_rdata", dmem_rdata, r.data);
        end
      end else begin
        chk("dmem_resp_known", {63'b0, dmem_resp}, 0);
        chk("dmem_rdata_idle", dmem_rdata, 0);
      end
    end
  end

  // Reference model state: outstanding request per requester, one transaction in flight.
  bit          busy, own_d, ip, dp;
  int          iss_cyc, due, starve, stale_at;
  logic [31:0] ia, da, dwd;
  logic [3:0]  ir, dr, dw;

  initial begin
    rst = 1'b1; imem_addr = '0; imem_rmask = '0; dmem_addr = '0; dmem_rmask = '0;
    dmem_wmask = '0; dmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    busy = 0; own_d = 0; ip = 0; dp = 0; iss_cyc = 0; due = 0; starve = 0; stale_at = -1;
    ia = '0; da = '0; dwd = '0; ir = '0; dr = '0; dw = '0;
    for (int n = 0; n < N_CYC; n++) begin
      int  t, kind;
      bit  do_rst, ireq, dreq, mr, waiting, deliver, i_done, d_done, gd;
      @(posedge clk);
      #1;
      t = cyc;
      if (n == 2) mon_en = 1'b1;
      waiting = busy && (t > iss_cyc);
      do_rst = (n < 2) || (n < 2200 && waiting && t < due && $urandom_range(0, 29) == 0);
      ireq = 0; dreq = 0;
      if (!do_rst) begin
        if (n < 1200) begin
          ireq = ($urandom_range(0, 9) < 3); dreq = ($urandom_range(0, 9) < 3);
        end else if (n < 2200) begin
          ireq = ($urandom_range(0, 1) == 0); dreq = 1;
        end else if (n < N_CYC - 40) begin
          if (!busy && !ip && !dp) begin
            ireq = ($urandom_range(0, 4) == 0); dreq = ($urandom_range(0, 4) == 0);
          end
        end
      end
      imem_addr  = $urandom;
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
      mem_rdata  = $urandom;
      imem_rmask = ireq ? 4'($urandom_range(1, 15)) : 4'h0;
      kind = $urandom_range(0, 2);
      dmem_rmask = (dreq && kind != 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      dmem_wmask = (dreq && kind != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (do_rst)       mr = 0;
      else if (waiting) mr = (t == due);
      else              mr = (t == stale_at) || ($urandom_range(0, 6) == 0);
      mem_resp = mr;
      rst = do_rst;
      if (do_rst) begin
        busy = 0; ip = 0; dp = 0; starve = 0; stale_at = t + 2;
        continue;
      end
      deliver = waiting && mr;
      i_done = deliver && !own_d;
      d_done = deliver && own_d;
      if (i_done) iq.push_back(rsp_t'{t, mem_rdata});
      if (d_done) dq.push_back(rsp_t'{t, mem_rdata});
      if (ireq && (!ip || i_done)) begin ia = imem_addr; ir = imem_rmask; ip = 1; end
      else if (i_done) ip = 0;
      if (dreq && (!dp || d_done)) begin
        da = dmem_addr; dr = dmem_rmask; dw = dmem_wmask; dwd = dmem_wdata; dp = 1;
      end else if (d_done) dp = 0;
      if (deliver) busy = 0;
      if (!busy && (ip || dp)) begin
        gd = dp && (!ip || starve != LIMIT);
        starve = (gd && ip) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        if (gd) iss_q.push_back(iss_t'{t + 1, da, (dw != 0) ? 4'h0 : dr, dw, dwd});
        else    iss_q.push_back(iss_t'{t + 1, ia, ir, 4'h0, 32'h0});
        busy = 1; own_d = gd; iss_cyc = t + 1; due = t + 2 + $urandom_range(0, 3);
      end
    end
    @(posedge clk);
    #1;
    imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0; mem_resp = 1'b0;
    @(negedge clk);
    chk("issue_queue_drained", 64'(iss_q.size()), 0);
    chk("imem_resp_queue_drained", 64'(iq.size()), 0);
    chk("dmem_resp_queue_drained", 64'(dq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
